// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state encoding and
// the access-legality rule used when an instruction is accepted.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // funct3[1:0] encodes the access size for every legal code
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b011, 3'b110, 3'b111: ok = 1'b0;
      default: begin
        case (f3[1:0])
          2'b00:   ok = 1'b1;
          2'b01:   ok = ~off[0];
          default: ok = (off == 2'b00);
        endcase
      end
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated store data and
// load lane extraction with sign or zero extension. No state, no backpressure.
module lsu_align
  import rv32_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte  = ld_word[{off, 3'b000} +: 8];
    ld_half  = off[1] ? ld_word[31:16] : ld_word[15:0];
    be       = 4'b1111;
    st_lanes = st_data;
    if (we) begin
      case (funct3)
        F3_SB, F3_LBU: begin
          be       = 4'b0001 << off;
          st_lanes = {4{st_data[7:0]}};
        end
        F3_SH, F3_LHU: begin
          be       = off[1] ? 4'b1100 : 4'b0011;
          st_lanes = {2{st_data[15:0]}};
        end
        F3_SW:   be = 4'b1111;
        default: be = 4'b1111;
      endcase
    end
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {24'd0, ld_byte};
      F3_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory stage: one access at a time over req/gnt/rvalid, stalling the core
// until a one-cycle done pulse; min 3 cycles for stores, 4 for loads, 2 for illegal accesses.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        al_we;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        timeout_hit;

  // In IDLE the aligner sees the live instruction; afterwards only the captured copy
  assign al_we  = (state_q == IDLE) ? mem_we     : dmem_we_q;
  assign al_f3  = (state_q == IDLE) ? funct3     : f3_q;
  assign al_off = (state_q == IDLE) ? addr[1:0]  : off_q;

  lsu_align u_align (
    .we       (al_we),
    .funct3   (al_f3),
    .off      (al_off),
    .st_data  (wdata),
    .ld_word  (dmem_rdata),
    .be       (al_be),
    .st_lanes (al_wdata),
    .ld_data  (al_rdata)
  );

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    f3_d         = f3_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (access_legal(funct3, addr[1:0])) begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_we;
            dmem_addr_d  = {addr[31:2], 2'b00};
            dmem_be_d    = al_be;
            dmem_wdata_d = al_wdata;
            f3_d         = funct3;
            off_d        = addr[1:0];
            cnt_d        = '0;
            state_d      = REQ;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = DONE;
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completing handshake wins over a timeout in the same cycle
        if (state_q == REQ && dmem_gnt) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (state_q == WAIT && dmem_rvalid) begin
          rdata_d = al_rdata;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          dmem_req_d = 1'b0;
          done_d     = 1'b1;
          err_d      = 1'b1;
          rdata_d    = 32'd0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
    end
  end

  assign stall      = mem_req && (state_q != DONE);
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-access cycle timeline model plus memory responder,
// one negedge compare process, directed corner cases and randomized traffic.
module tb_load_store_unit;

  localparam int T = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, done, err, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .err(err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---- reference model: plain arithmetic on the RV32I rules ----
  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    bytes = 1 << f3[1:0];
    return (int'(a[1:0]) % bytes) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    if (f3[1:0] == 2'd0) return 4'b0001 << a[1:0];
    if (f3[1:0] == 2'd1) return 4'b0011 << a[1:0];
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {4{d[7:0]}};
    if (f3[1:0] == 2'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // ---- expectations written by the driver, checked every negedge ----
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_dreq = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_be = 4'd0;
  logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0, cap_rdata = 32'd0;
  logic [3:0]  cap_be = 4'd0;
  logic        cap_err = 1'b0;
  int          stall_cnt = 0, dreq_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("done", 32'(done), 32'(exp_done));
      chk("dmem_req", 32'(dmem_req), 32'(exp_dreq));
      chk("rdata", rdata, exp_rdata);
      if (exp_done) chk("err", 32'(err), 32'(exp_err));
      if (exp_dreq) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
      if (dmem_req) begin
        dreq_cnt++;
        cap_addr  = dmem_addr;
        cap_be    = dmem_be;
        cap_wdata = dmem_wdata;
      end
      if (done) begin
        cap_rdata = rdata;
        cap_err   = err;
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_req     = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'($urandom_range(1));
    dmem_rdata  = $urandom();
    exp_stall   = 1'b0;
    exp_done    = 1'b0;
    exp_dreq    = 1'b0;
  endtask

  // to_mode: 0 normal, 1 never granted, 2 granted but read data never returns
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int glat, input int rlat, input int to_mode, input bit spur);
    bit legal, e_err;
    int gnt_c, rv_c, done_c;
    legal = m_legal(f3, a);
    e_err = !legal || (to_mode != 0);
    gnt_c = -1;
    rv_c  = -1;
    if (!legal) done_c = 1;
    else if (to_mode == 1) done_c = T + 1;
    else begin
      gnt_c = 1 + glat;
      if (we) done_c = gnt_c + 1;
      else if (to_mode == 2) done_c = T + 1;
      else begin
        rv_c   = gnt_c + 1 + rlat;
        done_c = rv_c + 1;
      end
    end
    stall_cnt = 0;
    dreq_cnt  = 0;
    for (int k = 0; k <= done_c; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        mem_req   = 1'b1;
        mem_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        exp_we    = we;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = m_be(we, f3, a);
        exp_wdata = m_wdata(f3, wd);
        exp_err   = e_err;
      end
      dmem_gnt    = (k == gnt_c);
      dmem_rvalid = (k == rv_c) ||
                    (spur && gnt_c > 0 && k >= 1 && k <= gnt_c && $urandom_range(1) == 1);
      dmem_rdata  = (k == rv_c) ? word : $urandom();
      exp_stall   = (k != done_c);
      exp_done    = (k == done_c);
      exp_dreq    = legal && k >= 1 && ((gnt_c > 0) ? (k <= gnt_c) : (k <= T));
      if (k == done_c) begin
        if (e_err) exp_rdata = 32'd0;
        else if (!we) exp_rdata = m_load(f3, a, word);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic reset_mid(input bit in_wait);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_stall = 1'b1; exp_done = 1'b0; exp_dreq = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h40; exp_be = 4'hF;
    @(posedge clk); #1;
    exp_dreq = 1'b1;
    dmem_gnt = in_wait;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    exp_dreq = !in_wait;
    @(negedge clk); #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk(in_wait ? "rst_wait_dmem_req" : "rst_req_dmem_req", 32'(dmem_req), 32'd0);
    chk(in_wait ? "rst_wait_done" : "rst_req_done", 32'(done), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    exp_rdata = 32'd0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_dreq = 1'b0;
    chk_en    = 1'b1;
    // a late response from the discarded access must have no effect
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    repeat (3) idle_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_dmem_req", 32'(dmem_req), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_dmem_be", 32'(dmem_be), 32'd0);
    chk("reset_dmem_addr", dmem_addr, 32'd0);
    chk("reset_dmem_wdata", dmem_wdata, 32'd0);
    chk("reset_dmem_we", 32'(dmem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    // SB to 0x103, granted on the third request cycle
    run_op(1'b1, 3'b000, 32'h103, 32'hAABBCCDD, 32'd0, 2, 0, 0, 1'b0);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hDDDDDDDD);
    chk("sb_stall_cycles", stall_cnt, 4);
    chk("sb_err", 32'(cap_err), 32'd0);
    idle_cycle();

    run_op(1'b0, 3'b000, 32'h102, 32'd0, 32'h80FF7F01, 0, 0, 0, 1'b0);
    chk("lb_rdata", cap_rdata, 32'hFFFFFFFF);
    run_op(1'b0, 3'b100, 32'h102, 32'd0, 32'h80FF7F01, 1, 2, 0, 1'b1);
    chk("lbu_rdata", cap_rdata, 32'h000000FF);
    run_op(1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF7F01, 0, 1, 0, 1'b0);
    chk("lh_rdata", cap_rdata, 32'hFFFF80FF);
    run_op(1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF7F01, 2, 0, 0, 1'b1);
    chk("lhu_rdata", cap_rdata, 32'h000080FF);
    idle_cycle();

    run_op(1'b0, 3'b010, 32'h201, 32'd0, 32'd0, 0, 0, 0, 1'b0);
    chk("lw_misaligned_err", 32'(cap_err), 32'd1);
    chk("lw_misaligned_rdata", cap_rdata, 32'd0);
    chk("lw_misaligned_no_req", dreq_cnt, 0);
    run_op(1'b0, 3'b011, 32'h200, 32'd0, 32'd0, 0, 0, 0, 1'b0);
    chk("f3_011_err", 32'(cap_err), 32'd1);
    chk("f3_011_no_req", dreq_cnt, 0);
    idle_cycle();

    run_op(1'b0, 3'b100, 32'h301, 32'd0, 32'h12345678, 0, 0, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 0, 0, 2, 1'b0);
    chk("timeout_rvalid_err", 32'(cap_err), 32'd1);
    chk("timeout_rvalid_rdata", cap_rdata, 32'd0);
    chk("timeout_rvalid_stall", stall_cnt, T + 1);
    run_op(1'b1, 3'b010, 32'h304, 32'h55, 32'd0, 0, 0, 1, 1'b0);
    chk("timeout_gnt_err", 32'(cap_err), 32'd1);
    chk("timeout_gnt_req_cycles", dreq_cnt, T);
    idle_cycle();

    // back-to-back SW then LW against a zero-wait memory
    run_op(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'd0, 0, 0, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h400, 32'd0, 32'hCAFEF00D, 0, 0, 0, 1'b0);
    chk("b2b_lw_rdata", cap_rdata, 32'hCAFEF00D);
    chk("b2b_lw_stall", stall_cnt, 3);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      we = 1'($urandom_range(1));
      if ($urandom_range(4) == 0) f3 = 3'($urandom_range(7));
      else if (we) f3 = 3'($urandom_range(2));
      else begin
        case ($urandom_range(4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      run_op(we, f3, $urandom(), $urandom(), $urandom(),
             $urandom_range(4), $urandom_range(4), 0, 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(2, 1)) idle_cycle();
      end
    end
    idle_cycle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
